vc_link_control_unit: RTL and testbench

VC_LINK_CONTROL_UNIT -- requirements
Module: vc_link_control_unit

---
 rtl/vc_link_control_unit.sv | 208 ++++++++++++++++++++
 tb/tb_vc_link_control_unit.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vc_link_control_unit.sv
// -----------------------------------------------------------------------------
// vc_link_control_unit
//
// Control unit for one virtual-channel input link of a router. A write FSM
// streams each incoming packet (header plus body flits) into a flit queue, a
// read FSM releases the head packet when the output link is granted, a packet
// counter tracks queued packets, and a route-computation request is raised
// whenever a new packet becomes the head of the channel.
//
// Parameters
//   FLITS_PER_PKT   flits per packet including the header (2..64)
//   BUFFER_PKTS     packet capacity of the flit queue (1..16)
//
// Ports
//   clk                   in   sole clock, rising edge
//   reset                 in   asynchronous active-high reset
//   header_field_din      in   header flit present on the input channel
//   transfer_strobe_din   in   output link granted, release head packet
//   write_strobe_dout     out  queue write enable
//   read_strobe_dout      out  queue read enable
//   routing_strobe_dout   out  one-cycle route-computation request
//   routing_source_dout   out  0 = route from input channel, 1 = queue head
//   credit_out_dout       out  one-cycle credit return upstream
//   packets_pending_dout  out  packets accepted but not yet started on read
//   buffer_full_dout      out  packets_pending_dout == BUFFER_PKTS
//   error_dout            out  sticky protocol-violation flag
//
// Configuration
//   LC_PROTOCOL_CHECK_EN  when defined, error_dout latches a header offered
//                         while full or a transfer offered while empty.
//                         When undefined, error_dout is tied low.
// -----------------------------------------------------------------------------
module vc_link_control_unit #(
  parameter  int FLITS_PER_PKT = 5,
  parameter  int BUFFER_PKTS   = 4,
  localparam int CNT_W         = $clog2(BUFFER_PKTS + 1),
  localparam int FC_W          = $clog2(FLITS_PER_PKT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             header_field_din,
  input  logic             transfer_strobe_din,
  output logic             write_strobe_dout,
  output logic             read_strobe_dout,
  output logic             routing_strobe_dout,
  output logic             routing_source_dout,
  output logic             credit_out_dout,
  output logic [CNT_W-1:0] packets_pending_dout,
  output logic             buffer_full_dout,
  output logic             error_dout
);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  // The start cycle emits the first strobe, so ACTIVE lasts FLITS_PER_PKT-1
  // cycles: the counter runs from FLITS_PER_PKT-2 down to 0.
  localparam logic [FC_W-1:0]  FC_RELOAD = FC_W'(FLITS_PER_PKT - 2);
  localparam logic [CNT_W-1:0] PKT_FULL  = CNT_W'(BUFFER_PKTS);

  state_t           r_wr_state, w_wr_state_next;
  state_t           r_rd_state, w_rd_state_next;
  logic [FC_W-1:0]  r_wr_cnt, w_wr_cnt_next;
  logic [FC_W-1:0]  r_rd_cnt, w_rd_cnt_next;
  logic [CNT_W-1:0] r_pkt_cnt;
  logic             r_rd_done;   // read FSM returned to IDLE last cycle

  logic w_full;
  logic w_empty;
  logic w_wr_start;
  logic w_rd_start;
  logic w_wr_strobe;
  logic w_rd_strobe;
  logic w_rd_last;

  assign w_full  = (r_pkt_cnt == PKT_FULL);
  assign w_empty = (r_pkt_cnt == '0);

  // NOTE: reset is folded into every combinational output so that strobes
  // read 0 while reset is held, even if inputs toggle during reset.
  assign w_wr_start = ~reset & (r_wr_state == ST_IDLE) & header_field_din & ~w_full;
  assign w_rd_start = ~reset & (r_rd_state == ST_IDLE) & transfer_strobe_din & ~w_empty;

  // ---------------------------------------------------------------------------
  // Write FSM
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before the case so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    w_wr_state_next = r_wr_state;
    w_wr_cnt_next   = r_wr_cnt;
    w_wr_strobe     = 1'b0;
    unique case (r_wr_state)
      ST_IDLE: begin
        if (w_wr_start) begin
          w_wr_state_next = ST_ACTIVE;
          w_wr_strobe     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_wr_strobe = 1'b1;
        if (r_wr_cnt == '0) begin
          w_wr_state_next = ST_IDLE;
          w_wr_cnt_next   = FC_RELOAD;
        end else begin
          w_wr_cnt_next = r_wr_cnt - FC_W'(1);
        end
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_rd_state_next = r_rd_state;
    w_rd_cnt_next   = r_rd_cnt;
    w_rd_strobe     = 1'b0;
    unique case (r_rd_state)
      ST_IDLE: begin
        if (w_rd_start) begin
          w_rd_state_next = ST_ACTIVE;
          w_rd_strobe     = 1'b1;
        end
      end
      ST_ACTIVE: begin
        w_rd_strobe = 1'b1;
        if (r_rd_cnt == '0) begin
          w_rd_state_next = ST_IDLE;
          w_rd_cnt_next   = FC_RELOAD;
        end else begin
          w_rd_cnt_next = r_rd_cnt - FC_W'(1);
        end
      end
    endcase
  end

  assign w_rd_last = (r_rd_state == ST_ACTIVE) && (r_rd_cnt == '0);

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_state <= ST_IDLE;
      r_rd_state <= ST_IDLE;
      r_wr_cnt   <= FC_RELOAD;
      r_rd_cnt   <= FC_RELOAD;
      r_rd_done  <= 1'b0;
    end else begin
      r_wr_state <= w_wr_state_next;
      r_rd_state <= w_rd_state_next;
      r_wr_cnt   <= w_wr_cnt_next;
      r_rd_cnt   <= w_rd_cnt_next;
      r_rd_done  <= w_rd_last;
    end
  end

  // Starts are already gated by full/empty, so the counter cannot wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pkt_cnt <= '0;
    end else if (w_wr_start && !w_rd_start) begin
      r_pkt_cnt <= r_pkt_cnt + CNT_W'(1);
    end else if (w_rd_start && !w_wr_start) begin
      r_pkt_cnt <= r_pkt_cnt - CNT_W'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign write_strobe_dout    = w_wr_strobe & ~reset;
  assign read_strobe_dout     = w_rd_strobe & ~reset;
  assign credit_out_dout      = w_rd_start;
  assign packets_pending_dout = r_pkt_cnt;
  assign buffer_full_dout     = w_full;
  assign routing_source_dout  = ~w_empty;

  // A new head appears either when a packet arrives at an empty, idle channel
  // (route from the input) or when a read finishes and more packets wait in
  // the queue (route from the queue head). Both terms OR into a single pulse.
  assign routing_strobe_dout = ~reset &
                               ((w_wr_start & w_empty & (r_rd_state == ST_IDLE)) |
                                (r_rd_done & ~w_empty));

`ifdef LC_PROTOCOL_CHECK_EN
  logic r_error;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_error <= 1'b0;
    end else if ((header_field_din && w_full && (r_wr_state == ST_IDLE)) ||
                 (transfer_strobe_din && w_empty && (r_rd_state == ST_IDLE))) begin
      r_error <= 1'b1;
    end
  end

  assign error_dout = r_error;
`else
  assign error_dout = 1'b0;
`endif

endmodule

// File: tb/tb_vc_link_control_unit.sv
// -----------------------------------------------------------------------------
// tb_vc_link_control_unit
//
// Directed bench for vc_link_control_unit with FLITS_PER_PKT=5, BUFFER_PKTS=4.
// Inputs change 1 ns after a rising edge; outputs are sampled on the falling
// edge. Each cycle compares a packed observation
//   {wr, rd, rt, src, cr, full, err, pending[2:0]}
// against a hand-computed expected vector.
// -----------------------------------------------------------------------------
module tb_vc_link_control_unit;

  logic       clk;
  logic       reset;
  logic       header_field_din;
  logic       transfer_strobe_din;
  logic       write_strobe_dout;
  logic       read_strobe_dout;
  logic       routing_strobe_dout;
  logic       routing_source_dout;
  logic       credit_out_dout;
  logic [2:0] packets_pending_dout;
  logic       buffer_full_dout;
  logic       error_dout;

  int n_cmp = 0;
  int n_mis = 0;

`ifdef LC_PROTOCOL_CHECK_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  vc_link_control_unit #(
    .FLITS_PER_PKT(5),
    .BUFFER_PKTS  (4)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .header_field_din    (header_field_din),
    .transfer_strobe_din (transfer_strobe_din),
    .write_strobe_dout   (write_strobe_dout),
    .read_strobe_dout    (read_strobe_dout),
    .routing_strobe_dout (routing_strobe_dout),
    .routing_source_dout (routing_source_dout),
    .credit_out_dout     (credit_out_dout),
    .packets_pending_dout(packets_pending_dout),
    .buffer_full_dout    (buffer_full_dout),
    .error_dout          (error_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [9:0] obs();
    return {write_strobe_dout, read_strobe_dout, routing_strobe_dout,
            routing_source_dout, credit_out_dout, buffer_full_dout,
            error_dout, packets_pending_dout};
  endfunction

  // Builds an expected vector in the same field order as obs().
  function automatic logic [9:0] mk(input logic wr, input logic rd,
                                    input logic rt, input logic src,
                                    input logic cr, input logic full,
                                    input logic err, input int pend);
    return {wr, rd, rt, src, cr, full, err, 3'(pend)};
  endfunction

  // Holds reset for two edges and releases it 1 ns after a rising edge.
  task automatic apply_reset();
    reset               = 1'b1;
    header_field_din    = 1'b0;
    transfer_strobe_din = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset               = 1'b1;
    header_field_din    = 1'b1;
    transfer_strobe_din = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== 10'b0) begin
        n_mis++;
        $display("FAIL reset cyc %0d: got %b want %b", i, obs(), 10'b0);
      end
    end
    header_field_din    = 1'b0;
    transfer_strobe_din = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Single header; header held through the body must be ignored.
  task automatic test_single_packet();
    logic [6:0] hdr;
    logic [9:0] ex [7];
    hdr   = 7'b0011111;
    ex[0] = mk(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i < 5; i++) ex[i] = mk(1, 0, 0, 1, 0, 0, 0, 1);
    ex[5] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    ex[6] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    apply_reset();
    for (int i = 0; i < 7; i++) begin
      header_field_din    = hdr[i];
      transfer_strobe_din = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs() !== ex[i]) begin
        n_mis++;
        $display("FAIL single_packet cyc %0d: got %b want %b", i, obs(), ex[i]);
      end
      next_cycle();
    end
  endtask

  // Continuous headers: a new packet starts every 5 cycles with no bubble.
  task automatic test_back_to_back();
    logic [9:0] ex [12];
    ex[0] = mk(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i < 6; i++)  ex[i] = mk(1, 0, 0, 1, 0, 0, 0, 1);
    for (int i = 6; i < 11; i++) ex[i] = mk(1, 0, 0, 1, 0, 0, 0, 2);
    ex[11] = mk(1, 0, 0, 1, 0, 0, 0, 3);
    apply_reset();
    for (int i = 0; i < 12; i++) begin
      header_field_din    = (i < 11);
      transfer_strobe_din = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (obs() !== ex[i]) begin
        n_mis++;
        $display("FAIL back_to_back cyc %0d: got %b want %b", i, obs(), ex[i]);
      end
      next_cycle();
    end
  endtask

  // Four packets fill the buffer; a fifth header is refused.
  task automatic test_fill_buffer();
    logic [9:0] ex [3];
    ex[0] = mk(0, 0, 0, 1, 0, 1, 0, 4);
    ex[1] = mk(0, 0, 0, 1, 0, 1, ERR, 4);
    ex[2] = mk(0, 0, 0, 1, 0, 1, ERR, 4);
    apply_reset();
    header_field_din    = 1'b1;
    transfer_strobe_din = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (write_strobe_dout !== 1'b1) begin
        n_mis++;
        $display("FAIL fill_wr_strobe cyc %0d: got %b want 1", i, write_strobe_dout);
      end
      next_cycle();
    end
    for (int i = 0; i < 3; i++) begin
      header_field_din = (i != 1);
      @(negedge clk);
      n_cmp++;
      if (obs() !== ex[i]) begin
        n_mis++;
        $display("FAIL fill_full cyc %0d: got %b want %b", i, obs(), ex[i]);
      end
      next_cycle();
    end
  endtask

  // Two packets queued, then released one at a time.
  task automatic test_transfer();
    logic [12:0] xfer;
    logic [9:0]  ex [13];
    xfer  = 13'b0000_0100_11111;
    ex[0] = mk(0, 1, 0, 1, 1, 0, 0, 2);
    for (int i = 1; i < 5; i++) ex[i] = mk(0, 1, 0, 1, 0, 0, 0, 1);
    ex[5] = mk(0, 0, 1, 1, 0, 0, 0, 1);
    ex[6] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    ex[7] = mk(0, 1, 0, 1, 1, 0, 0, 1);
    for (int i = 8; i < 12; i++) ex[i] = mk(0, 1, 0, 0, 0, 0, 0, 0);
    ex[12] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    apply_reset();
    header_field_din = 1'b1;
    repeat (10) next_cycle();
    header_field_din = 1'b0;
    for (int i = 0; i < 13; i++) begin
      transfer_strobe_din = xfer[i];
      @(negedge clk);
      n_cmp++;
      if (obs() !== ex[i]) begin
        n_mis++;
        $display("FAIL transfer cyc %0d: got %b want %b", i, obs(), ex[i]);
      end
      next_cycle();
    end
  endtask

  // Write start and read start in the same cycle with one packet queued.
  task automatic test_simultaneous();
    logic [9:0] ex [6];
    ex[0] = mk(1, 1, 0, 1, 1, 0, 0, 1);
    for (int i = 1; i < 5; i++) ex[i] = mk(1, 1, 0, 1, 0, 0, 0, 1);
    ex[5] = mk(0, 0, 1, 1, 0, 0, 0, 1);
    apply_reset();
    header_field_din = 1'b1;
    next_cycle();
    header_field_din = 1'b0;
    repeat (5) next_cycle();
    for (int i = 0; i < 6; i++) begin
      header_field_din    = (i == 0);
      transfer_strobe_din = (i == 0);
      @(negedge clk);
      n_cmp++;
      if (obs() !== ex[i]) begin
        n_mis++;
        $display("FAIL simultaneous cyc %0d: got %b want %b", i, obs(), ex[i]);
      end
      next_cycle();
    end
  endtask

  // Header arriving while the last queued packet is being read: no immediate
  // route request; it is issued from the queue head when the read ends.
  task automatic test_route_while_reading();
    logic [9:0] ex [7];
    ex[0] = mk(0, 1, 0, 1, 1, 0, 0, 1);
    ex[1] = mk(1, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 2; i < 5; i++) ex[i] = mk(1, 1, 0, 1, 0, 0, 0, 1);
    ex[5] = mk(1, 0, 1, 1, 0, 0, 0, 1);
    ex[6] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    apply_reset();
    header_field_din = 1'b1;
    next_cycle();
    header_field_din = 1'b0;
    repeat (5) next_cycle();
    for (int i = 0; i < 7; i++) begin
      header_field_din    = (i == 1);
      transfer_strobe_din = (i == 0);
      @(negedge clk);
      n_cmp++;
      if (obs() !== ex[i]) begin
        n_mis++;
        $display("FAIL route_while_reading cyc %0d: got %b want %b", i, obs(), ex[i]);
      end
      next_cycle();
    end
  endtask

  // Transfer with nothing queued is ignored.
  task automatic test_transfer_empty();
    logic [9:0] ex [3];
    ex[0] = mk(0, 0, 0, 0, 0, 0, 0, 0);
    ex[1] = mk(0, 0, 0, 0, 0, 0, ERR, 0);
    ex[2] = mk(0, 0, 0, 0, 0, 0, ERR, 0);
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      header_field_din    = 1'b0;
      transfer_strobe_din = (i == 0);
      @(negedge clk);
      n_cmp++;
      if (obs() !== ex[i]) begin
        n_mis++;
        $display("FAIL transfer_empty cyc %0d: got %b want %b", i, obs(), ex[i]);
      end
      next_cycle();
    end
  endtask

  // Reset asserted between edges mid-packet, then a fresh 5-flit packet.
  task automatic test_async_reset();
    logic [9:0] ex [6];
    ex[0] = mk(1, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 1; i < 5; i++) ex[i] = mk(1, 0, 0, 1, 0, 0, 0, 1);
    ex[5] = mk(0, 0, 0, 1, 0, 0, 0, 1);
    apply_reset();
    header_field_din = 1'b1;
    next_cycle();
    header_field_din = 1'b0;
    repeat (2) next_cycle();
    n_cmp++;
    if (obs() !== mk(1, 0, 0, 1, 0, 0, 0, 1)) begin
      n_mis++;
      $display("FAIL async_reset_pre: got %b want %b", obs(), mk(1, 0, 0, 1, 0, 0, 0, 1));
    end
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (obs() !== 10'b0) begin
      n_mis++;
      $display("FAIL async_reset_immediate: got %b want %b", obs(), 10'b0);
    end
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      header_field_din = (i == 0);
      @(negedge clk);
      n_cmp++;
      if (obs() !== ex[i]) begin
        n_mis++;
        $display("FAIL async_reset_restart cyc %0d: got %b want %b", i, obs(), ex[i]);
      end
      next_cycle();
    end
  endtask

  initial begin
    reset               = 1'b1;
    header_field_din    = 1'b0;
    transfer_strobe_din = 1'b0;
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_fill_buffer();
    test_transfer();
    test_simultaneous();
    test_route_while_reading();
    test_transfer_empty();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
